brick_table: RTL and testbench



---
 rtl/brick_table.sv | 181 ++++++++++++++++++
 tb/tb_brick_table.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/brick_table.sv
// brick_table: brick-state store for the brick-breaker game.
//
// Fills itself with a grid layout after reset or on init_req, then serves one
// registered read per cycle and accepts hits that deactivate bricks.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-low reset
//   init_req       one-cycle pulse, restarts the layout fill
//   rd_idx         read index (sampled every cycle)
//   rd_x/rd_y      registered coordinates of entry rd_idx
//   rd_w/rd_h      registered width/height of entry rd_idx
//   rd_active      registered active bit of entry rd_idx
//   rd_valid       rd_* outputs are meaningful
//   hit_valid      hit request strobe
//   hit_idx        brick to deactivate
//   hit_done       one-cycle pulse, one cycle after an accepted hit
//   hit_was_active qualifies hit_done: brick was active before the hit
//   active_count   number of active bricks
//   all_cleared    registered: in RUN with no active bricks left
//   init_busy      high while the layout fill is running
module brick_table #(
  parameter int NUM_BRICKS = 40,
  parameter int IDX_W      = 6,
  parameter int COORD_W    = 8,
  parameter int SIZE_W     = 4,
  parameter int COLS       = 8,
  parameter int BRICK_W    = 12,
  parameter int BRICK_H    = 6,
  parameter int ORIGIN_X   = 4,
  parameter int ORIGIN_Y   = 8,
  parameter int GAP        = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic [SIZE_W-1:0]  rd_w,
  output logic [SIZE_W-1:0]  rd_h,
  output logic               rd_active,
  output logic               rd_valid,
  input  logic               hit_valid,
  input  logic [IDX_W-1:0]   hit_idx,
  output logic               hit_done,
  output logic               hit_was_active,
  output logic [IDX_W:0]     active_count,
  output logic               all_cleared,
  output logic               init_busy
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [COORD_W-1:0] X_ORG  = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0] Y_ORG  = COORD_W'(ORIGIN_Y);
  localparam logic [COORD_W-1:0] X_STEP = COORD_W'(BRICK_W + GAP);
  localparam logic [COORD_W-1:0] Y_STEP = COORD_W'(BRICK_H + GAP);

  typedef enum logic {INIT, RUN} state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]   fill_idx;
  logic [IDX_W-1:0]   col;
  // x_acc/y_acc are the running coordinates of the entry at fill_idx; y_acc
  // stands in for the row counter so no multiply by row is ever needed.
  logic [COORD_W-1:0] x_acc;
  logic [COORD_W-1:0] y_acc;

  logic [COORD_W-1:0]    x_mem [NUM_BRICKS];
  logic [COORD_W-1:0]    y_mem [NUM_BRICKS];
  logic [NUM_BRICKS-1:0] active_mem;

  logic fill_last;
  logic fill_we;
  logic rd_in_range;
  logic hit_in_range;
  logic hit_accept;
  logic hit_hits_active;

  assign fill_last    = (fill_idx == IDX_W'(NUM_BRICKS - 1));
  assign fill_we      = (state == INIT) && !init_req;
  // Compare with one extra bit so NUM_BRICKS == 2^IDX_W still works.
  assign rd_in_range  = ({1'b0, rd_idx}  < CNT_W'(NUM_BRICKS));
  assign hit_in_range = ({1'b0, hit_idx} < CNT_W'(NUM_BRICKS));
  // init_req wins over a hit in the same cycle.
  assign hit_accept      = (state == RUN) && !init_req && hit_valid && hit_in_range;
  assign hit_hits_active = hit_accept && active_mem[hit_idx];

  assign init_busy = (state == INIT);

  always_ff @(posedge clk) begin
    if (!reset) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT: if (!init_req && fill_last) state_next = RUN;
      RUN:  if (init_req)               state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  // Fill sequencer: counters park at zero outside an active fill so any new
  // INIT (reset, init_req, or restart) begins from entry 0.
  always_ff @(posedge clk) begin
    if (!reset || state == RUN || init_req || fill_last) begin
      fill_idx <= '0;
      col      <= '0;
      x_acc    <= X_ORG;
      y_acc    <= Y_ORG;
    end else begin
      fill_idx <= fill_idx + 1'b1;
      if (col == IDX_W'(COLS - 1)) begin
        col   <= '0;
        x_acc <= X_ORG;
        y_acc <= y_acc + Y_STEP;
      end else begin
        col   <= col + 1'b1;
        x_acc <= x_acc + X_STEP;
      end
    end
  end

  // Table storage. Width and height are identical for every entry, so only
  // coordinates and the active bit are stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (fill_we) begin
        x_mem[fill_idx]      <= x_acc;
        y_mem[fill_idx]      <= y_acc;
        active_mem[fill_idx] <= 1'b1;
      end
      if (hit_accept) active_mem[hit_idx] <= 1'b0;
    end
  end

  // Registered read port; the non-blocking write above means a read and hit
  // of the same entry in one cycle returns the pre-hit active bit.
  always_ff @(posedge clk) begin
    if (!reset || state != RUN || init_req || !rd_in_range) begin
      rd_x      <= '0;
      rd_y      <= '0;
      rd_w      <= '0;
      rd_h      <= '0;
      rd_active <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_x      <= x_mem[rd_idx];
      rd_y      <= y_mem[rd_idx];
      rd_w      <= SIZE_W'(BRICK_W);
      rd_h      <= SIZE_W'(BRICK_H);
      rd_active <= active_mem[rd_idx];
      rd_valid  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_done       <= 1'b0;
      hit_was_active <= 1'b0;
      active_count   <= '0;
      all_cleared    <= 1'b0;
    end else begin
      hit_done       <= hit_accept;
      hit_was_active <= hit_hits_active;
      all_cleared    <= (state == RUN) && !init_req && (active_count == '0);
      if (state == INIT) begin
        if (!init_req && fill_last) active_count <= CNT_W'(NUM_BRICKS);
        else                        active_count <= '0;
      end else if (init_req) begin
        active_count <= '0;
      end else if (hit_hits_active && active_count != '0) begin
        active_count <= active_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_brick_table.sv
// tb_brick_table: scoreboard bench for brick_table with default parameters.
// Stimulus pushes expected read/hit responses into queues; a monitor pops and
// compares whenever rd_valid or hit_done is presented.
module tb_brick_table;

  localparam int NB   = 40;
  localparam int IDLE = 63;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init_req = 1'b0;
  logic [5:0] rd_idx = 6'(IDLE);
  logic       hit_valid = 1'b0;
  logic [5:0] hit_idx = '0;
  logic [7:0] rd_x, rd_y;
  logic [3:0] rd_w, rd_h;
  logic       rd_active, rd_valid, hit_done, hit_was_active;
  logic [6:0] active_count;
  logic       all_cleared, init_busy;

  brick_table dut (
    .clk(clk), .reset(reset), .init_req(init_req), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w), .rd_h(rd_h),
    .rd_active(rd_active), .rd_valid(rd_valid),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_done(hit_done),
    .hit_was_active(hit_was_active), .active_count(active_count),
    .all_cleared(all_cleared), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; int x; int y; int act; } rd_exp_t;
  typedef struct { int due; int was; } hit_exp_t;
  rd_exp_t  rd_q[$];
  hit_exp_t hit_q[$];

  logic [NB-1:0] model_active = '1;
  int            model_count  = 0;
  bit            model_run    = 1'b0;

  function automatic void checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endfunction

  // Monitor: compare every presented read or hit response with the queue head.
  initial begin
    rd_exp_t  re;
    hit_exp_t he;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        if (rd_q.size() == 0) checkOutput("rd_unexpected", 1, 0);
        else begin
          re = rd_q.pop_front();
          checkOutput("rd_latency", cycle, re.due);
          checkOutput("rd_x", int'(rd_x), re.x);
          checkOutput("rd_y", int'(rd_y), re.y);
          checkOutput("rd_w", int'(rd_w), 12);
          checkOutput("rd_h", int'(rd_h), 6);
          checkOutput("rd_active", int'(rd_active), re.act);
        end
      end
      if (hit_done) begin
        if (hit_q.size() == 0) checkOutput("hit_unexpected", 1, 0);
        else begin
          he = hit_q.pop_front();
          checkOutput("hit_latency", cycle, he.due);
          checkOutput("hit_was_active", int'(hit_was_active), he.was);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One stimulus cycle; expected coordinates for reads are hand-supplied.
  task automatic applyStimulus(input bit do_rd, input int ridx, input int ex, input int ey,
                               input bit do_hit, input int hidx, input bit do_init);
    @(negedge clk);
    rd_idx    = do_rd ? 6'(ridx) : 6'(IDLE);
    hit_valid = do_hit;
    hit_idx   = 6'(hidx);
    init_req  = do_init;
    if (do_rd && ridx < NB && model_run && !do_init)
      rd_q.push_back('{cycle + 1, ex, ey, int'(model_active[ridx])});
    if (do_hit && hidx < NB && model_run && !do_init) begin
      hit_q.push_back('{cycle + 1, int'(model_active[hidx])});
      if (model_active[hidx]) begin
        model_active[hidx] = 1'b0;
        model_count--;
      end
    end
    if (do_init) begin
      model_run    = 1'b0;
      model_count  = 0;
      model_active = '1;
    end
    @(negedge clk);
    rd_idx    = 6'(IDLE);
    hit_valid = 1'b0;
    init_req  = 1'b0;
  endtask

  task automatic countInit(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (init_busy && n < 200);
    model_run   = 1'b1;
    model_count = NB;
  endtask

  task automatic assertReset();
    @(negedge clk);
    reset        = 1'b0;
    model_run    = 1'b0;
    model_count  = 0;
    model_active = '1;
  endtask

  task automatic releaseAndCount(output int n);
    @(negedge clk);
    reset = 1'b1;
    countInit(n);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_rd_x"}, int'(rd_x), 0);
    checkOutput({tag, "_rd_y"}, int'(rd_y), 0);
    checkOutput({tag, "_rd_w"}, int'(rd_w), 0);
    checkOutput({tag, "_rd_h"}, int'(rd_h), 0);
    checkOutput({tag, "_rd_active"}, int'(rd_active), 0);
    checkOutput({tag, "_rd_valid"}, int'(rd_valid), 0);
    checkOutput({tag, "_hit_done"}, int'(hit_done), 0);
    checkOutput({tag, "_hit_was_active"}, int'(hit_was_active), 0);
    checkOutput({tag, "_active_count"}, int'(active_count), 0);
    checkOutput({tag, "_all_cleared"}, int'(all_cleared), 0);
    checkOutput({tag, "_init_busy"}, int'(init_busy), 1);
  endtask

  // Hand-computed layout vectors: idx, x, y.
  int rd_vec [5][3] = '{'{0, 4, 8}, '{7, 102, 8}, '{8, 4, 16}, '{39, 102, 40}, '{20, 60, 24}};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("por");

    releaseAndCount(n);
    checkOutput("init_cycles", n, 40);
    checkOutput("count_after_init", int'(active_count), 40);
    checkOutput("cleared_after_init", int'(all_cleared), 0);

    foreach (rd_vec[i]) applyStimulus(1, rd_vec[i][0], rd_vec[i][1], rd_vec[i][2], 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 1, 5, 0);
    checkOutput("count_hit5", int'(active_count), model_count);
    applyStimulus(0, 0, 0, 0, 1, 5, 0);
    checkOutput("count_hit5_again", int'(active_count), 39);
    applyStimulus(1, 5, 74, 8, 0, 0, 0);

    applyStimulus(1, 9, 18, 16, 1, 9, 0);
    applyStimulus(1, 9, 18, 16, 0, 0, 0);
    checkOutput("count_hit9", int'(active_count), 38);

    applyStimulus(1, 45, 0, 0, 1, 45, 0);
    checkOutput("rd_oob_valid", int'(rd_valid), 0);
    checkOutput("rd_oob_x", int'(rd_x), 0);
    checkOutput("count_hit45", int'(active_count), 38);

    for (int i = 0; i < NB; i++) applyStimulus(0, 0, 0, 0, 1, i, 0);
    checkOutput("count_all_hit", int'(active_count), 0);
    checkOutput("cleared_same_cycle", int'(all_cleared), 0);
    @(negedge clk);
    checkOutput("cleared_next_cycle", int'(all_cleared), 1);

    applyStimulus(0, 0, 0, 0, 1, 3, 1);
    checkOutput("reinit_busy", int'(init_busy), 1);
    checkOutput("reinit_cleared", int'(all_cleared), 0);
    checkOutput("reinit_count", int'(active_count), 0);
    countInit(n);
    checkOutput("reinit_cycles", n, 40);
    checkOutput("reinit_count_done", int'(active_count), 40);
    applyStimulus(1, 39, 102, 40, 0, 0, 0);

    for (int i = 0; i < 28; i++) applyStimulus(0, 0, 0, 0, 1, i, 0);
    checkOutput("count_12", int'(active_count), 12);
    assertReset();
    @(posedge clk);
    #1;
    checkResetOutputs("run_reset");
    releaseAndCount(n);
    checkOutput("run_reset_cycles", n, 40);
    checkOutput("run_reset_count", int'(active_count), 40);

    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 4, 0);
    repeat (18) @(posedge clk);
    checkOutput("mid_init_busy", int'(init_busy), 1);
    assertReset();
    @(posedge clk);
    #1;
    checkResetOutputs("init_reset");
    releaseAndCount(n);
    checkOutput("init_reset_cycles", n, 40);
    applyStimulus(1, 20, 60, 24, 0, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("rd_queue_drained", rd_q.size(), 0);
    checkOutput("hit_queue_drained", hit_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
